// File: rtl/bus_master_pkg.sv
// Shared bus widths, field positions and command record for the bus master and its responders.
package bus_master_pkg;

    localparam int BUS_ADDR_WIDTH = 8;
    localparam int BUS_DATA_WIDTH = 32;

    // bus_in layout, low bits first: clock, reset, req, rd_wr_l, addr, wr_data
    localparam int BUS_FIELD_CLK      = 0;
    localparam int BUS_FIELD_RESET_L  = 1;
    localparam int BUS_FIELD_REQ      = 2;
    localparam int BUS_FIELD_RD_WR_L  = 3;
    localparam int BUS_ADDR_START     = 4;
    localparam int BUS_ADDR_END       = BUS_ADDR_START + BUS_ADDR_WIDTH - 1;
    localparam int BUS_WR_DATA_START  = BUS_ADDR_END + 1;
    localparam int BUS_WR_DATA_END    = BUS_WR_DATA_START + BUS_DATA_WIDTH - 1;
    localparam int BUS_IN_WIDTH       = BUS_WR_DATA_END + 1;

    // bus_out layout: read data in the low bits, ack above it
    localparam int BUS_DATA_START     = 0;
    localparam int BUS_DATA_END       = BUS_DATA_START + BUS_DATA_WIDTH - 1;
    localparam int BUS_FIELD_ACK      = BUS_DATA_END + 1;
    localparam int BUS_OUT_WIDTH      = BUS_FIELD_ACK + 1;

    localparam int TIMEOUT_CNT_WIDTH  = 8;

    typedef struct packed {
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic                      rd_wr_l;
        logic [BUS_DATA_WIDTH-1:0] wr_data;
    } cmd_t;

    function automatic logic [BUS_IN_WIDTH-1:0] bus_in_pack(
        input logic clk,
        input logic reset_l,
        input logic req,
        input cmd_t cmd
    );
        logic [BUS_IN_WIDTH-1:0] v;
        v = '0;
        v[BUS_FIELD_CLK]                         = clk;
        v[BUS_FIELD_RESET_L]                     = reset_l;
        v[BUS_FIELD_REQ]                         = req;
        v[BUS_FIELD_RD_WR_L]                     = cmd.rd_wr_l;
        v[BUS_ADDR_END:BUS_ADDR_START]           = cmd.addr;
        v[BUS_WR_DATA_END:BUS_WR_DATA_START]     = cmd.wr_data;
        return v;
    endfunction

endpackage

// File: rtl/bus_master_timeout.sv
// WAIT-cycle counter: expired is high during the TIMEOUT-th consecutive enabled cycle.
module bus_timeout
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic bus_clk,
    input  logic bus_reset_l,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT - 1);

    logic [TIMEOUT_CNT_WIDTH-1:0] count;

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Count holds k-1 in the k-th enabled cycle, so the flag rises in cycle TIMEOUT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/bus_master.sv
// Single-outstanding bus master: host command -> one-cycle bus req -> wait for ack -> host response.
// Build option BUS_MASTER_TIMEOUT_EN adds a WAIT timeout that returns rsp_err=1.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic                      bus_clk,
    input  logic                      bus_reset_l,
    output logic [BUS_IN_WIDTH-1:0]   bus_in,
    input  logic [BUS_OUT_WIDTH-1:0]  bus_out,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                      cmd_rd_wr_l,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BUS_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_err,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state;
    logic   req;
    cmd_t   cmd_q;

    logic                      ack;
    logic [BUS_DATA_WIDTH-1:0] bus_rdata;

    assign ack       = bus_out[BUS_FIELD_ACK];
    assign bus_rdata = bus_out[BUS_DATA_END:BUS_DATA_START];

`ifdef BUS_MASTER_TIMEOUT_EN
    logic to_clear;
    logic to_enable;
    logic to_expired;

    assign to_clear  = (state != S_WAIT);
    assign to_enable = (state == S_WAIT);

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .clear       (to_clear),
        .enable      (to_enable),
        .expired     (to_expired)
    );
`endif

    // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
    // a response transfers on an edge where rsp_valid && rsp_ready. cmd_ready is high
    // only in IDLE and rsp_valid only in RESP, so exactly one transaction is in flight.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            req       <= 1'b0;
            cmd_q     <= '{addr: '0, rd_wr_l: 1'b1, wr_data: '0};
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= '{addr: cmd_addr, rd_wr_l: cmd_rd_wr_l, wr_data: cmd_wr_data};
                        cmd_ready <= 1'b0;
                        req       <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    req   <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (ack) begin
                        rsp_data  <= cmd_q.rd_wr_l ? bus_rdata : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                    else if (to_expired) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Clock and reset ride the bus untouched so responders share the master's domain.
    assign bus_in    = bus_in_pack(bus_clk, bus_reset_l, req, cmd_q);
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a single-cycle responder at address 0x10.
module tb_bus_master;
  import bus_master_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic                      bus_clk = 1'b0;
  logic                      bus_reset_l = 1'b0;
  logic [BUS_IN_WIDTH-1:0]   bus_in;
  logic [BUS_OUT_WIDTH-1:0]  bus_out;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic [BUS_ADDR_WIDTH-1:0] cmd_addr = '0;
  logic                      cmd_rd_wr_l = 1'b1;
  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [BUS_DATA_WIDTH-1:0] rsp_data;
  logic                      rsp_err;
  logic [1:0]                state_dbg;

  int tests = 0;
  int fails = 0;

  bus_master #(.TIMEOUT(16)) dut (
    .bus_clk     (bus_clk),
    .bus_reset_l (bus_reset_l),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_rd_wr_l (cmd_rd_wr_l),
    .cmd_wr_data (cmd_wr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 bus_clk = ~bus_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // bus_in field decode
  logic                      b_clk, b_reset_l, b_req, b_rd_wr_l;
  logic [BUS_ADDR_WIDTH-1:0] b_addr;
  logic [BUS_DATA_WIDTH-1:0] b_wr_data;
  assign b_clk     = bus_in[BUS_FIELD_CLK];
  assign b_reset_l = bus_in[BUS_FIELD_RESET_L];
  assign b_req     = bus_in[BUS_FIELD_REQ];
  assign b_rd_wr_l = bus_in[BUS_FIELD_RD_WR_L];
  assign b_addr    = bus_in[BUS_ADDR_END:BUS_ADDR_START];
  assign b_wr_data = bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];

  // responder at 0x10 clocked from the bus, plus a directly injected ack/data
  logic [BUS_DATA_WIDTH-1:0] resp_reg = '0;
  logic                      resp_ack;
  logic [BUS_DATA_WIDTH-1:0] resp_rdata;
  logic                      inj_ack = 1'b0;
  logic [BUS_DATA_WIDTH-1:0] inj_data = '0;

  always @(posedge b_clk or negedge b_reset_l) begin
    if (!b_reset_l) begin
      resp_ack   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_ack   <= 1'b0;
      resp_rdata <= '0;
      if (b_req && b_addr == 8'h10) begin
        resp_ack <= 1'b1;
        if (b_rd_wr_l) resp_rdata <= resp_reg;
        else           resp_reg   <= b_wr_data;
      end
    end
  end

  assign bus_out = {resp_ack | inj_ack, resp_rdata | inj_data};

  // scoreboard bookkeeping
  task automatic chk(input string tag, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic rw, input logic [31:0] d);
    cmd_valid   = 1'b1;
    cmd_addr    = a;
    cmd_rd_wr_l = rw;
    cmd_wr_data = d;
    tick(1);
    cmd_valid   = 1'b0;
  endtask

  int seen_valid;

  initial begin
    // reset state
    #12;
    chk("rst_state", state_dbg === ST_IDLE);
    chk("rst_cmd_ready", cmd_ready === 1'b1);
    chk("rst_rsp_valid", rsp_valid === 1'b0);
    chk("rst_rsp_err", rsp_err === 1'b0);
    chk("rst_rsp_data", rsp_data === 32'h0);
    chk("rst_req", b_req === 1'b0);
    chk("rst_addr", b_addr === 8'h00);
    chk("rst_wr_data", b_wr_data === 32'h0);
    chk("rst_rd_wr_l", b_rd_wr_l === 1'b1);
    chk("rst_passthru", b_reset_l === 1'b0);
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    tick(1);
    chk("rel_passthru", b_reset_l === 1'b1);

    // ack in IDLE is ignored
    inj_ack  = 1'b1;
    inj_data = 32'hDEADBEEF;
    tick(1);
    chk("idle_ack_state", state_dbg === ST_IDLE);
    chk("idle_ack_valid", rsp_valid === 1'b0);
    chk("idle_ack_data", rsp_data === 32'h0);
    inj_ack  = 1'b0;
    inj_data = '0;

    // write 0xA5A5A5A5 to 0x10
    cmd_valid   = 1'b1;
    cmd_addr    = 8'h10;
    cmd_rd_wr_l = 1'b0;
    cmd_wr_data = 32'hA5A5A5A5;
    chk("wr_cmd_ready", cmd_ready === 1'b1);
    tick(1);
    cmd_valid = 1'b0;
    chk("wr_req_state", state_dbg === ST_REQ);
    chk("wr_req_hi", b_req === 1'b1);
    chk("wr_req_addr", b_addr === 8'h10);
    chk("wr_req_data", b_wr_data === 32'hA5A5A5A5);
    chk("wr_req_rw", b_rd_wr_l === 1'b0);
    chk("wr_req_cmd_ready", cmd_ready === 1'b0);
    tick(1);
    chk("wr_wait_state", state_dbg === ST_WAIT);
    chk("wr_wait_req_lo", b_req === 1'b0);
    chk("wr_wait_addr", b_addr === 8'h10);
    chk("wr_resp_reg", resp_reg === 32'hA5A5A5A5);
    tick(1);
    chk("wr_rsp_valid", rsp_valid === 1'b1);
    chk("wr_rsp_err", rsp_err === 1'b0);
    chk("wr_rsp_data", rsp_data === 32'h0);
    tick(1);
    chk("wr_done_state", state_dbg === ST_IDLE);
    chk("wr_done_valid", rsp_valid === 1'b0);
    chk("wr_done_cmd_ready", cmd_ready === 1'b1);
    chk("wr_data_held", b_wr_data === 32'hA5A5A5A5);

    // load 0x12345678 through the master, then read it back under backpressure
    issue(8'h10, 1'b0, 32'h12345678);
    tick(3);
    chk("wr2_state", state_dbg === ST_IDLE);
    rsp_ready = 1'b0;
    issue(8'h10, 1'b1, 32'h0);
    chk("rd_req_rw", b_rd_wr_l === 1'b1);
    tick(1);
    chk("rd_wait_no_valid", rsp_valid === 1'b0);
    tick(1);
    chk("rd_valid_3cyc", rsp_valid === 1'b1);
    chk("rd_data", rsp_data === 32'h12345678);
    chk("rd_err", rsp_err === 1'b0);
    cmd_valid   = 1'b1;
    cmd_addr    = 8'h7F;
    cmd_rd_wr_l = 1'b1;
    cmd_wr_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_state", state_dbg === ST_RESP);
      chk("bp_valid", rsp_valid === 1'b1);
      chk("bp_data", rsp_data === 32'h12345678);
      chk("bp_err", rsp_err === 1'b0);
      chk("bp_cmd_ready", cmd_ready === 1'b0);
    end
    rsp_ready = 1'b1;
    tick(1);
    chk("b2b_idle_state", state_dbg === ST_IDLE);
    chk("b2b_idle_ready", cmd_ready === 1'b1);
    chk("b2b_idle_valid", rsp_valid === 1'b0);
    tick(1);
    cmd_valid = 1'b0;
    chk("unmapped_req_state", state_dbg === ST_REQ);
    chk("unmapped_req_addr", b_addr === 8'h7F);

    // unmapped read: no ack through WAIT cycle 16
    tick(16);
    chk("unmapped_wait16_state", state_dbg === ST_WAIT);
    chk("unmapped_wait16_valid", rsp_valid === 1'b0);
`ifdef BUS_MASTER_TIMEOUT_EN
    tick(1);
    chk("to_state", state_dbg === ST_RESP);
    chk("to_valid", rsp_valid === 1'b1);
    chk("to_err", rsp_err === 1'b1);
    chk("to_data", rsp_data === 32'h0);
    tick(1);
    chk("to_done_state", state_dbg === ST_IDLE);
    issue(8'h7F, 1'b1, 32'h0);
    tick(2);
`else
    tick(84);
    chk("wait100_valid", rsp_valid === 1'b0);
    chk("wait100_req", b_req === 1'b0);
`endif
    chk("pre_rst_state", state_dbg === ST_WAIT);

    // reset during WAIT
    bus_reset_l = 1'b0;
    #1;
    chk("wrst_state", state_dbg === ST_IDLE);
    chk("wrst_req", b_req === 1'b0);
    chk("wrst_valid", rsp_valid === 1'b0);
    chk("wrst_cmd_ready", cmd_ready === 1'b1);
    chk("wrst_rd_wr_l", b_rd_wr_l === 1'b1);
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rsp_valid) seen_valid++;
    end
    chk("wrst_no_rsp", seen_valid === 0);
    chk("wrst_idle", state_dbg === ST_IDLE);

    // ack arriving in WAIT cycle 16 is a success
    issue(8'h7F, 1'b1, 32'h0);
    tick(15);
    chk("ack16_wait15", state_dbg === ST_WAIT);
    tick(1);
    chk("ack16_wait16", state_dbg === ST_WAIT);
    inj_ack  = 1'b1;
    inj_data = 32'hCAFEF00D;
    tick(1);
    inj_ack  = 1'b0;
    inj_data = '0;
    chk("ack16_valid", rsp_valid === 1'b1);
    chk("ack16_err", rsp_err === 1'b0);
    chk("ack16_data", rsp_data === 32'hCAFEF00D);
    tick(1);
    chk("ack16_done", state_dbg === ST_IDLE);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of WAIT cycles without ack before an error response (range 2..255).
REQ-002 SHALL take bus widths and field positions from bus_params.v: BUS_IN_WIDTH, BUS_OUT_WIDTH, BUS_ADDR_WIDTH, BUS_DATA_WIDTH, BUS_FIELD_ACK, BUS_DATA_START/END.
REQ-003 SHALL have port bus_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port bus_reset_l  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port bus_in  out  BUS_IN_WIDTH  bus to all responders: bus_clk, bus_reset_l, req, addr, rd_wr_l, wr_data.
REQ-006 SHALL have port bus_out  in  BUS_OUT_WIDTH  OR of all responder returns: data and ack.
REQ-007 SHALL have port cmd_valid  in  1  host command present.
REQ-008 SHALL have port cmd_ready  out  1  command accepted this cycle.
REQ-009 SHALL have ports cmd_addr (in, BUS_ADDR_WIDTH), cmd_rd_wr_l (in, 1; 1=read, 0=write) and cmd_wr_data (in, BUS_DATA_WIDTH).
REQ-010 SHALL have port rsp_valid  out  1  response present.
REQ-011 SHALL have port rsp_ready  in  1  host takes response.
REQ-012 SHALL have ports rsp_data (out, BUS_DATA_WIDTH, read data, 0 for writes and errors) and rsp_err (out, 1, timeout).

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; cmd_valid && cmd_ready registers addr, rd_wr_l and wr_data, then enters REQ.
REQ-015 SHALL assert bus req for exactly one cycle (REQ state); addr, rd_wr_l and wr_data stay stable from REQ until leaving WAIT.
REQ-016 SHALL, in WAIT, sample bus_out ack each cycle; ack=1 captures the bus_out data field into rsp_data (read) or 0 (write), sets rsp_err=0, enters RESP.
REQ-017 SHALL, with a single-cycle-latency responder, see ack in the first WAIT cycle, giving 3 cycles from acceptance to rsp_valid.
REQ-018 SHALL count WAIT cycles; if the count reaches TIMEOUT with no ack: rsp_err=1, rsp_data=0, enter RESP.
REQ-019 SHALL treat ack and timeout in the same cycle as ack (success).
REQ-020 SHALL ignore ack in IDLE, REQ and RESP (no state change, no data capture).
REQ-021 SHALL, in RESP, hold rsp_valid=1 and stable rsp_data/rsp_err until rsp_ready=1, then go to IDLE; back-to-back commands therefore have one IDLE cycle between them.
REQ-022 SHALL drive bus req=0 and hold wr_data at its last value outside REQ.

Reset
REQ-023 SHALL, on bus_reset_l low, asynchronously force IDLE, req=0, rsp_valid=0, rsp_err=0, rsp_data=0, addr=0, wr_data=0, rd_wr_l=1, timeout count=0.
REQ-024 SHALL abandon any transaction in progress at reset, with no response generated after release.
REQ-025 SHALL pass bus_clk and bus_reset_l into bus_in unmodified.

Configuration
REQ-026 SHALL honour macro BUS_MASTER_TIMEOUT_EN: defined -> REQ-018/019 active; undefined -> no counter logic, WAIT holds until ack, rsp_err tied 0, TIMEOUT unused.

Structure
REQ-027 SHALL keep bus widths and field positions in shared bus_params.v; FSM state encodings stay local.
REQ-028 SHALL place the timeout counter in sub-module bus_timeout (clear, enable, expired), instantiated only under BUS_MASTER_TIMEOUT_EN.

Verification
REQ-029 SHALL cover: write addr 0x10 data 0xA5A5A5A5 to a responder at 0x10 -> one-cycle req, responder register reads 0xA5A5A5A5, rsp_err=0, rsp_data=0.
REQ-030 SHALL cover: read addr 0x10, responder returns 0x12345678 -> rsp_valid 3 cycles after acceptance, rsp_data=0x12345678.
REQ-031 SHALL cover: read of unmapped addr 0x7F with TIMEOUT=16 -> rsp_err=1 and rsp_data=0 after 16 WAIT cycles; without the macro, still waiting at cycle 100.
REQ-032 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_err stable, cmd_ready=0 throughout.
REQ-033 SHALL cover: bus_reset_l low during WAIT -> immediate IDLE, req=0, no rsp_valid after release.
REQ-034 SHALL cover: ack on the 16th WAIT cycle (TIMEOUT=16) -> success, rsp_err=0.
